// File: rtl/rsa_engine_arbiter.sv
// Two-requester round-robin front end for one modular-exponentiation engine.
// Latches operands, pulses eng_start, watches for a hung engine, returns result/err.
//
// Ports:
//   clk, reset          : rising-edge clock, async active-low reset
//   req[1:0]            : per-requester job request (level, held until done)
//   base/exp/mod 0 and 1: per-requester operands, sampled only on grant
//   gnt[1:0]            : one-hot owner of the current job, 0 when idle
//   done[1:0]           : 1-cycle completion pulse to the owner
//   res, err            : result and error flag, valid with done, held after
//   eng_start/eng_abort : 1-cycle pulses to the engine
//   eng_base/exp/mod    : latched operands to the engine
//   eng_res, eng_done   : engine result and completion (rising edge counts)
module rsa_engine_arbiter #(
  parameter int WIDTH   = 128,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] base0,
  input  logic [WIDTH-1:0] exp0,
  input  logic [WIDTH-1:0] mod0,
  input  logic [WIDTH-1:0] base1,
  input  logic [WIDTH-1:0] exp1,
  input  logic [WIDTH-1:0] mod1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] res,
  output logic             err,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_base,
  output logic [WIDTH-1:0] eng_exp,
  output logic [WIDTH-1:0] eng_mod,
  output logic             eng_abort,
  input  logic [WIDTH-1:0] eng_res,
  input  logic             eng_done
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic             last_q, last_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic             eng_done_q;

  logic             pick1;
  logic             done_rise;
  logic [WIDTH-1:0] mod_sel;

  // On a tie, serve whoever was not served last.
  assign pick1     = req[1] & (~req[0] | ~last_q);
  assign mod_sel   = pick1 ? mod1 : mod0;
  assign done_rise = eng_done & ~eng_done_q;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    res_d     = res_q;
    err_d     = err_q;
    last_d    = last_q;
    timer_d   = timer_q;
    base_d    = base_q;
    exp_d     = exp_q;
    mod_d     = mod_q;
    eng_start = 1'b0;
    eng_abort = 1'b0;
    done      = 2'b00;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d  = pick1 ? 2'b10 : 2'b01;
          base_d = pick1 ? base1 : base0;
          exp_d  = pick1 ? exp1 : exp0;
          mod_d  = mod_sel;
          if (mod_sel == '0) begin
            err_d   = 1'b1;
            res_d   = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        eng_start = 1'b1;
        timer_d   = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise) begin
          res_d   = eng_res;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timer_q == TMAX) begin
          eng_abort = 1'b1;
          err_d     = 1'b1;
          res_d     = '0;
          state_d   = S_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        done    = gnt_q;
        last_d  = gnt_q[1];
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= 2'b00;
      res_q      <= '0;
      err_q      <= 1'b0;
      last_q     <= 1'b1;
      timer_q    <= '0;
      base_q     <= '0;
      exp_q      <= '0;
      mod_q      <= '0;
      eng_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      res_q      <= res_d;
      err_q      <= err_d;
      last_q     <= last_d;
      timer_q    <= timer_d;
      base_q     <= base_d;
      exp_q      <= exp_d;
      mod_q      <= mod_d;
      eng_done_q <= eng_done;
    end
  end

  assign gnt      = gnt_q;
  assign res      = res_q;
  assign err      = err_q;
  assign eng_base = base_q;
  assign eng_exp  = exp_q;
  assign eng_mod  = mod_q;

endmodule

// File: tb/tb_rsa_engine_arbiter.sv
// Bench for rsa_engine_arbiter: behavioural modexp engine, scoreboard of
// expected completions, one task per scenario.
module tb_rsa_engine_arbiter;

  localparam int W = 32;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] base0 = '0, exp0 = '0, mod0 = '0;
  logic [W-1:0] base1 = '0, exp1 = '0, mod1 = '0;
  logic [1:0]   gnt, done;
  logic [W-1:0] res;
  logic         err, eng_start, eng_abort;
  logic [W-1:0] eng_base, eng_exp, eng_mod;
  logic [W-1:0] eng_res = '0;
  logic         eng_done = 1'b0;

  int checks = 0;
  int fails = 0;

  rsa_engine_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req),
    .base0(base0), .exp0(exp0), .mod0(mod0),
    .base1(base1), .exp1(exp1), .mod1(mod1),
    .gnt(gnt), .done(done), .res(res), .err(err),
    .eng_start(eng_start), .eng_base(eng_base),
    .eng_exp(eng_exp), .eng_mod(eng_mod),
    .eng_abort(eng_abort), .eng_res(eng_res),
    .eng_done(eng_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   d;
    logic [W-1:0] r;
    logic         e;
  } exp_t;
  exp_t sb[$];

  function automatic logic [W-1:0] modexp(
    input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
    logic [2*W-1:0] acc, bb;
    if (m == '0) return '0;
    acc = 1;
    bb = {{W{1'b0}}, b} % {{W{1'b0}}, m};
    for (int i = 0; i < W; i++) begin
      if (e[i]) acc = (acc * bb) % {{W{1'b0}}, m};
      bb = (bb * bb) % {{W{1'b0}}, m};
    end
    return acc[W-1:0];
  endfunction

  // Engine model: fixed latency, can be told to hang, honours abort.
  int           lat = 3;
  bit           hang = 0;
  bit           busy;
  int           cnt;
  logic [W-1:0] m_res;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 0;
      cnt      <= 0;
      eng_done <= 1'b0;
    end else begin
      eng_done <= 1'b0;
      if (eng_abort) begin
        busy <= 0;
      end else if (eng_start && !hang) begin
        busy  <= 1;
        cnt   <= lat;
        m_res <= modexp(eng_base, eng_exp, eng_mod);
      end else if (busy) begin
        if (cnt <= 1) begin
          busy     <= 0;
          eng_done <= 1'b1;
          eng_res  <= m_res;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // Passive activity counters.
  int cyc = 0, starts = 0, aborts = 0, dones = 0;
  int start_cyc = 0, abort_cyc = 0;
  bit both_seen = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (eng_start) begin starts <= starts + 1; start_cyc <= cyc; end
    if (eng_abort) begin aborts <= aborts + 1; abort_cyc <= cyc; end
    if (done != 2'b00) dones <= dones + 1;
    if (gnt == 2'b11) both_seen <= 1;
  end

  task automatic wait_done(output logic [1:0] d, output logic [W-1:0] r,
                           output logic e, output int n, output bit to);
    to = 1; n = 0; d = '0; r = '0; e = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (done != 2'b00) begin
        d = done; r = res; e = err; to = 0;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle(3);
    checks++;
    if (gnt !== 2'b00 || done !== 2'b00) begin
      fails++;
      $display("FAIL reset_gnt_done got %b/%b want 00/00", gnt, done);
    end
    checks++;
    if (eng_start !== 1'b0 || eng_abort !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_pulses got %b%b%b want 000", eng_start, eng_abort, err);
    end
    checks++;
    if (res !== '0 || eng_base !== '0 || eng_exp !== '0 || eng_mod !== '0) begin
      fails++;
      $display("FAIL reset_data got %0d %0d %0d %0d want 0", res, eng_base, eng_exp, eng_mod);
    end
    reset = 1'b1;
    idle(3);
    checks++;
    if (gnt !== 2'b00 || starts != 0) begin
      fails++;
      $display("FAIL idle_after_reset got gnt=%b starts=%0d want 00/0", gnt, starts);
    end
  endtask

  task automatic test_single;
    logic [1:0] d; logic [W-1:0] r; logic e; int n; bit to; exp_t x; int s0;
    s0 = starts;
    base0 = 920; exp0 = 17; mod0 = 2773;
    req = 2'b01;
    sb.push_back('{2'b01, 948, 1'b0});
    @(negedge clk);
    base0 = 1; exp0 = 1;
    wait_done(d, r, e, n, to);
    req = 2'b00;
    x = sb.pop_front();
    checks++;
    if (to || d !== x.d || r !== x.r || e !== x.e) begin
      fails++;
      $display("FAIL single_result got to=%0d d=%b r=%0d e=%b want d=%b r=%0d e=%b",
               to, d, r, e, x.d, x.r, x.e);
    end
    checks++;
    if (starts - s0 != 1) begin
      fails++;
      $display("FAIL single_starts got %0d want 1", starts - s0);
    end
    checks++;
    if (eng_base !== 920 || eng_exp !== 17 || eng_mod !== 2773) begin
      fails++;
      $display("FAIL operand_latch got %0d %0d %0d want 920 17 2773", eng_base, eng_exp, eng_mod);
    end
    idle(2);
  endtask

  task automatic test_both;
    logic [1:0] d; logic [W-1:0] r; logic e; int n; bit to; exp_t x;
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    idle(1);
    both_seen = 0;
    base0 = 920; exp0 = 17; mod0 = 2773;
    base1 = 948; exp1 = 157; mod1 = 2773;
    req = 2'b11;
    sb.push_back('{2'b01, 948, 1'b0});
    sb.push_back('{2'b10, 920, 1'b0});
    for (int k = 0; k < 2; k++) begin
      wait_done(d, r, e, n, to);
      req = req & ~d;
      x = sb.pop_front();
      checks++;
      if (to || d !== x.d || r !== x.r || e !== x.e) begin
        fails++;
        $display("FAIL both_job%0d got to=%0d d=%b r=%0d e=%b want d=%b r=%0d e=%b",
                 k, to, d, r, e, x.d, x.r, x.e);
      end
    end
    req = 2'b00;
    checks++;
    if (both_seen) begin
      fails++;
      $display("FAIL gnt_onehot got 11 want never 11");
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    logic [1:0] d; logic [W-1:0] r; logic e; int n; bit to; exp_t x;
    base0 = 920; exp0 = 17; mod0 = 2773;
    base1 = 5; exp1 = 3; mod1 = 7;
    req = 2'b11;
    sb.push_back('{2'b01, 948, 1'b0});
    sb.push_back('{2'b10, 6, 1'b0});
    sb.push_back('{2'b01, 948, 1'b0});
    for (int k = 0; k < 3; k++) begin
      wait_done(d, r, e, n, to);
      if (k == 1) req = 2'b01;
      if (k == 2) req = 2'b00;
      x = sb.pop_front();
      checks++;
      if (to || d !== x.d || r !== x.r || e !== x.e) begin
        fails++;
        $display("FAIL b2b_job%0d got to=%0d d=%b r=%0d e=%b want d=%b r=%0d e=%b",
                 k, to, d, r, e, x.d, x.r, x.e);
      end
    end
    req = 2'b00;
    idle(2);
  endtask

  task automatic test_modzero;
    logic [1:0] d; logic [W-1:0] r; logic e; int n; bit to; exp_t x; int s0;
    s0 = starts;
    base1 = 3; exp1 = 5; mod1 = 0;
    req = 2'b10;
    sb.push_back('{2'b10, 0, 1'b1});
    wait_done(d, r, e, n, to);
    req = 2'b00;
    x = sb.pop_front();
    checks++;
    if (to || d !== x.d || e !== x.e || r !== x.r) begin
      fails++;
      $display("FAIL modzero_result got to=%0d d=%b r=%0d e=%b want d=%b r=%0d e=%b",
               to, d, r, e, x.d, x.r, x.e);
    end
    checks++;
    if (n != 1) begin
      fails++;
      $display("FAIL modzero_latency got %0d want 1", n);
    end
    idle(3);
    checks++;
    if (starts != s0) begin
      fails++;
      $display("FAIL modzero_nostart got %0d want 0", starts - s0);
    end
  endtask

  task automatic test_timeout;
    logic [1:0] d; logic [W-1:0] r; logic e; int n; bit to; exp_t x; int a0;
    a0 = aborts;
    hang = 1;
    base0 = 920; exp0 = 17; mod0 = 2773;
    req = 2'b01;
    sb.push_back('{2'b01, 0, 1'b1});
    wait_done(d, r, e, n, to);
    req = 2'b00;
    hang = 0;
    x = sb.pop_front();
    checks++;
    if (to || d !== x.d || r !== x.r || e !== x.e) begin
      fails++;
      $display("FAIL timeout_result got to=%0d d=%b r=%0d e=%b want d=%b r=%0d e=%b",
               to, d, r, e, x.d, x.r, x.e);
    end
    checks++;
    if (aborts - a0 != 1 || abort_cyc - start_cyc != TO) begin
      fails++;
      $display("FAIL timeout_abort got n=%0d dist=%0d want 1/%0d",
               aborts - a0, abort_cyc - start_cyc, TO);
    end
    idle(2);
    base1 = 5; exp1 = 3; mod1 = 7;
    req = 2'b10;
    sb.push_back('{2'b10, 6, 1'b0});
    wait_done(d, r, e, n, to);
    req = 2'b00;
    x = sb.pop_front();
    checks++;
    if (to || d !== x.d || r !== x.r || e !== x.e) begin
      fails++;
      $display("FAIL after_timeout got to=%0d d=%b r=%0d e=%b want d=%b r=%0d e=%b",
               to, d, r, e, x.d, x.r, x.e);
    end
    idle(2);
  endtask

  task automatic test_reset_mid;
    logic [1:0] d; logic [W-1:0] r; logic e; int n; bit to; exp_t x;
    int s0, d0;
    bit seen;
    lat = 10;
    s0 = starts;
    base0 = 920; exp0 = 17; mod0 = 2773;
    req = 2'b01;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (eng_start) seen = 1;
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL midreset_start got none want eng_start");
    end
    idle(2);
    d0 = dones;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (gnt !== 2'b00 || done !== 2'b00 || eng_start !== 1'b0 || res !== '0) begin
      fails++;
      $display("FAIL midreset_async got gnt=%b done=%b st=%b res=%0d want 00/00/0/0",
               gnt, done, eng_start, res);
    end
    req = 2'b00;
    idle(2);
    reset = 1'b1;
    s0 = starts;
    idle(5);
    checks++;
    if (starts != s0 || dones != d0) begin
      fails++;
      $display("FAIL midreset_quiet got starts=%0d dones=%0d want 0/0",
               starts - s0, dones - d0);
    end
    lat = 3;
    req = 2'b01;
    sb.push_back('{2'b01, 948, 1'b0});
    wait_done(d, r, e, n, to);
    req = 2'b00;
    x = sb.pop_front();
    checks++;
    if (to || d !== x.d || r !== x.r || e !== x.e) begin
      fails++;
      $display("FAIL midreset_rerun got to=%0d d=%b r=%0d e=%b want d=%b r=%0d e=%b",
               to, d, r, e, x.d, x.r, x.e);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_back_to_back();
    test_modzero();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
